mem_burst_responder: RTL and testbench
======================================

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 32, line size in bytes; WORDS = BLOCK_SIZE/(DATA_WIDTH/8), power of two, >= 2.
REQ-004 SHALL have parameter NUM_LINES, default 64, stored lines, power of two.
REQ-005 SHALL have parameter LATENCY, default 4, wait cycles between request accept and first data beat, range 0..255.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, cache request present.
REQ-009 SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-010 SHALL have port req_write, input, 1, 1 = writeback line, 0 = refill read.
REQ-011 SHALL have port req_addr, input, ADDRESS_WIDTH, byte address; byte-offset bits ignored.
REQ-012 SHALL have port wr_valid, input, 1, writeback beat present.
REQ-013 SHALL have port wr_data, input, DATA_WIDTH, writeback beat data.
REQ-014 SHALL have port wr_ready, output, 1, writeback beat accepted.
REQ-015 SHALL have port rd_valid, output, 1, refill beat present.
REQ-016 SHALL have port rd_data, output, DATA_WIDTH, refill beat data.
REQ-017 SHALL have port rd_last, output, 1, final refill beat.
REQ-018 SHALL have port rd_ready, input, 1, cache accepts refill beat.
REQ-019 SHALL have port wb_ack, output, 1, one-cycle pulse: writeback complete.
REQ-020 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-021 SHALL store NUM_LINES x WORDS words; line index = req_addr[log2(BLOCK_SIZE) +: log2(NUM_LINES)], upper bits ignored (aliasing).
REQ-022 SHALL implement states IDLE, WAIT, WBURST, RBURST, ACK.
REQ-023 SHALL drive req_ready = 1 only in IDLE; a request is accepted on req_valid && req_ready, latching index and req_write.
REQ-024 SHALL on accept go to WAIT and load a latency counter with LATENCY; if LATENCY = 0 go directly to WBURST/RBURST.
REQ-025 SHALL in WAIT decrement counter each cycle; on counter reaching 1 move to WBURST (write) or RBURST (read) next cycle, giving exactly LATENCY WAIT cycles.
REQ-026 SHALL in WBURST drive wr_ready = 1; each wr_valid && wr_ready cycle writes wr_data to word[beat] of the latched line and increments a log2(WORDS)-bit beat counter from 0.
REQ-027 SHALL after beat WORDS-1 is accepted go to ACK; ACK drives wb_ack = 1 for exactly one cycle then returns to IDLE.
REQ-028 SHALL in RBURST drive rd_valid = 1, rd_data = word[beat] of latched line, rd_last = (beat == WORDS-1).
REQ-029 SHALL hold rd_data, rd_last and beat stable while rd_valid && !rd_ready (backpressure).
REQ-030 SHALL on rd_valid && rd_ready advance beat; on the rd_last handshake return to IDLE with no ack pulse.
REQ-031 SHALL ignore wr_valid outside WBURST and rd_ready outside RBURST; req_valid outside IDLE is not accepted.
REQ-032 SHALL make a completed writeback visible to any subsequently accepted read of the same index.
REQ-033 SHALL wrap beat counter to 0 on burst completion; beats always start at word 0.

Reset
REQ-034 SHALL on reset_n low asynchronously force IDLE, beat = 0, counter = 0, req_ready = 1 after first clk edge-independent release (combinational from IDLE), wr_ready = 0, rd_valid = 0, rd_last = 0, rd_data = 0, wb_ack = 0, busy = 0.
REQ-035 SHALL NOT reset storage contents; reset mid-WBURST leaves words already written intact and remaining words unchanged.

Verification
REQ-036 Write line addr 0x40 (LATENCY=4), beats 0x11..0x18 back-to-back -> wr_ready rises exactly 4 cycles after accept, wb_ack pulses 1 cycle after beat 8, busy low next cycle.
REQ-037 Read addr 0x40 after REQ-036 -> rd_data 0x11..0x18 in order, rd_last only with 0x18, 4 WAIT cycles before rd_valid.
REQ-038 Read with rd_ready low 3 cycles at beat 2 -> rd_data holds 0x13, no beat skipped or repeated.
REQ-039 Write with wr_valid gaps (every other cycle) -> all 8 words stored, wb_ack only after 8th accepted beat.
REQ-040 LATENCY=0 build, req_valid held high during burst -> data phase begins cycle after accept, second request accepted only in IDLE after completion.
REQ-041 reset_n low after 3 write beats -> all outputs at reset values immediately; later read returns new words 0..2, old contents 3..7.

Source files
------------

// File: rtl/mem_burst_responder_if.sv
// Request/writeback/refill bundle between a cache and the burst memory responder.
// The master modport is the cache side; slave is the responder side.
interface mem_burst_responder_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     wr_valid;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_ready;
  logic                     rd_valid;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_last;
  logic                     rd_ready;
  logic                     wb_ack;
  logic                     busy;

  modport master (
    output req_valid, req_write, req_addr, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last, wb_ack, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last, wb_ack, busy
  );
endinterface

// File: rtl/mem_burst_responder.sv
// Line-granular burst memory model: accepts a writeback or refill request, waits
// LATENCY cycles, then streams WORDS beats in or out of the addressed line.
module mem_burst_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int NUM_LINES     = 64,
  parameter int LATENCY       = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  mem_burst_responder_if.slave  bus
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int WORDS          = BLOCK_SIZE / BYTES_PER_WORD;
  localparam int OFF_W          = $clog2(BLOCK_SIZE);
  localparam int IDX_W          = $clog2(NUM_LINES);
  localparam int BEAT_W         = $clog2(WORDS);
  localparam int DEPTH          = NUM_LINES * WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WBURST,
    S_RBURST,
    S_ACK
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_cnt;
  logic [BEAT_W-1:0]    r_beat;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_write;

  // Storage is deliberately outside the reset domain so contents survive reset.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_last_beat;
  logic                  w_req_ready;
  logic                  w_wr_ready;
  logic                  w_rd_valid;
  logic                  w_rd_last;
  logic                  w_wb_ack;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused_addr;

  // Offset bits and bits above the line index only alias; they are never decoded.
  assign w_unused_addr = ^bus.req_addr;

  assign w_last_beat = (r_beat == BEAT_W'(WORDS - 1));
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_wr_fire   = bus.wr_valid && w_wr_ready;
  assign w_rd_fire   = w_rd_valid && bus.rd_ready;

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_rd_valid  = 1'b0;
    w_rd_last   = 1'b0;
    w_wb_ack    = 1'b0;
    w_rd_data   = '0;
    w_busy      = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            w_next = bus.req_write ? S_WBURST : S_RBURST;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd1) begin
          w_next = r_write ? S_WBURST : S_RBURST;
        end
      end
      S_WBURST: begin
        w_wr_ready = 1'b1;
        if (bus.wr_valid && w_last_beat) begin
          w_next = S_ACK;
        end
      end
      S_RBURST: begin
        w_rd_valid = 1'b1;
        w_rd_last  = w_last_beat;
        w_rd_data  = r_mem[{r_idx, r_beat}];
        if (bus.rd_ready && w_last_beat) begin
          w_next = S_IDLE;
        end
      end
      S_ACK: begin
        w_wb_ack = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= bus.req_addr[OFF_W +: IDX_W];
        r_write <= bus.req_write;
        r_cnt   <= 8'(LATENCY);
        r_beat  <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      // Counter is exactly log2(WORDS) wide, so the final beat wraps it to 0.
      if (w_wr_fire || w_rd_fire) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[{r_idx, r_beat}] <= bus.wr_data;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_data   = w_rd_data;
  assign bus.rd_last   = w_rd_last;
  assign bus.wb_ack    = w_wb_ack;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: a LATENCY=4 and a LATENCY=0 instance checked
// against a line-array reference model with directed and randomized bursts.
module tb_mem_burst_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BS    = 32;
  localparam int NL    = 64;
  localparam int WORDS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, rst_n1, sel;
  logic        t_req_valid, t_req_write, t_wr_valid, t_rd_ready;
  logic [31:0] t_req_addr, t_wr_data;

  mem_burst_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus0 ();
  mem_burst_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus1 ();

  assign bus0.req_valid = t_req_valid & ~sel;
  assign bus0.req_write = t_req_write;
  assign bus0.req_addr  = t_req_addr;
  assign bus0.wr_valid  = t_wr_valid & ~sel;
  assign bus0.wr_data   = t_wr_data;
  assign bus0.rd_ready  = t_rd_ready & ~sel;
  assign bus1.req_valid = t_req_valid & sel;
  assign bus1.req_write = t_req_write;
  assign bus1.req_addr  = t_req_addr;
  assign bus1.wr_valid  = t_wr_valid & sel;
  assign bus1.wr_data   = t_wr_data;
  assign bus1.rd_ready  = t_rd_ready & sel;

  logic        o_req_ready, o_wr_ready, o_rd_valid, o_rd_last, o_wb_ack, o_busy;
  logic [31:0] o_rd_data;
  assign o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign o_wr_ready  = sel ? bus1.wr_ready  : bus0.wr_ready;
  assign o_rd_valid  = sel ? bus1.rd_valid  : bus0.rd_valid;
  assign o_rd_last   = sel ? bus1.rd_last   : bus0.rd_last;
  assign o_rd_data   = sel ? bus1.rd_data   : bus0.rd_data;
  assign o_wb_ack    = sel ? bus1.wb_ack    : bus0.wb_ack;
  assign o_busy      = sel ? bus1.busy      : bus0.busy;

  mem_burst_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .NUM_LINES(NL), .LATENCY(4)
  ) u_dut_lat4 (
    .clk(clk), .reset_n(rst_n0), .bus(bus0)
  );

  mem_burst_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .NUM_LINES(NL), .LATENCY(0)
  ) u_dut_lat0 (
    .clk(clk), .reset_n(rst_n1), .bus(bus1)
  );

  // Reference model: one array of lines per instance, plus a written-line flag.
  logic [31:0] m_mem [2][NL][WORDS];
  bit          m_vld [2][NL];
  logic [31:0] wdat  [WORDS];

  int checks = 0;
  int errors = 0;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / BS) % NL);
  endfunction

  function automatic int lat_of();
    return sel ? 0 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, o_req_ready, 1);
    chk({tag, "_wr_ready"},  o_wr_ready,  0);
    chk({tag, "_rd_valid"},  o_rd_valid,  0);
    chk({tag, "_rd_last"},   o_rd_last,   0);
    chk({tag, "_rd_data"},   o_rd_data,   0);
    chk({tag, "_wb_ack"},    o_wb_ack,    0);
    chk({tag, "_busy"},      o_busy,      0);
  endtask

  task automatic do_write(input logic [31:0] addr, input int gap_mode, input bit hold_req,
                          input int abort_after);
    int  s, ln, waits, acc, cyc;
    bit  v, tog;
    s  = sel ? 1 : 0;
    ln = line_of(addr);
    chk("wr_req_ready", o_req_ready, 1);
    t_req_valid = 1'b1; t_req_write = 1'b1; t_req_addr = addr;
    step();
    if (!hold_req) t_req_valid = 1'b0;
    waits = 0;
    while (!o_wr_ready && waits < 300) begin
      chk("wr_wait_busy", o_busy, 1);
      t_wr_valid = 1'b1; t_wr_data = 32'hDEAD_0000 + 32'(waits);
      step();
      waits++;
    end
    chk("wr_latency", 32'(waits), 32'(lat_of()));
    acc = 0; cyc = 0; tog = 1'b0;
    while (acc < WORDS && cyc < 300) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      chk("wr_ready", o_wr_ready, 1);
      chk("wb_ack_early", o_wb_ack, 0);
      if (hold_req) chk("req_ready_in_burst", o_req_ready, 0);
      t_wr_valid = v; t_wr_data = wdat[acc];
      step();
      cyc++;
      if (v) begin
        m_mem[s][ln][acc] = wdat[acc];
        acc++;
      end
      if (acc == abort_after) begin
        if (s == 0) rst_n0 = 1'b0; else rst_n1 = 1'b0;
        t_wr_valid = 1'b0; t_req_valid = 1'b0;
        #1;
        chk_reset_outputs("midburst_reset");
        #3;
        if (s == 0) rst_n0 = 1'b1; else rst_n1 = 1'b1;
        step();
        return;
      end
    end
    chk("wr_beats", 32'(acc), WORDS);
    t_wr_valid = 1'b0;
    chk("wb_ack_pulse", o_wb_ack, 1);
    chk("wr_ready_ack", o_wr_ready, 0);
    chk("busy_ack", o_busy, 1);
    if (hold_req) chk("req_ready_ack", o_req_ready, 0);
    step();
    chk("wb_ack_end", o_wb_ack, 0);
    chk("busy_end", o_busy, 0);
    chk("req_ready_end", o_req_ready, 1);
    m_vld[s][ln] = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall_beat, input int stall_n,
                         input bit rnd_bp, input bit hold_req);
    int  s, ln, waits, i, cyc, left;
    bit  r;
    s  = sel ? 1 : 0;
    ln = line_of(addr);
    chk("rd_req_ready", o_req_ready, 1);
    t_req_valid = 1'b1; t_req_write = 1'b0; t_req_addr = addr;
    step();
    if (!hold_req) t_req_valid = 1'b0;
    waits = 0;
    while (!o_rd_valid && waits < 300) begin
      chk("rd_wait_busy", o_busy, 1);
      t_rd_ready = 1'($urandom_range(0, 1));
      step();
      waits++;
    end
    chk("rd_latency", 32'(waits), 32'(lat_of()));
    i = 0; cyc = 0; left = stall_n;
    while (i < WORDS && cyc < 300) begin
      chk("rd_valid", o_rd_valid, 1);
      if (m_vld[s][ln]) chk("rd_data", o_rd_data, m_mem[s][ln][i]);
      chk("rd_last", o_rd_last, 32'(i == WORDS - 1));
      chk("wr_ready_in_read", o_wr_ready, 0);
      if (hold_req) chk("req_ready_in_burst", o_req_ready, 0);
      if (i == stall_beat && left > 0) begin
        r = 1'b0;
        left--;
      end else if (rnd_bp) begin
        r = 1'($urandom_range(0, 1));
      end else begin
        r = 1'b1;
      end
      t_rd_ready = r; t_wr_valid = 1'b1; t_wr_data = $urandom;
      step();
      cyc++;
      if (r) i++;
    end
    chk("rd_beats", 32'(i), WORDS);
    t_rd_ready = 1'b0; t_wr_valid = 1'b0;
    chk("rd_valid_end", o_rd_valid, 0);
    chk("busy_rd_end", o_busy, 0);
    chk("no_ack_on_read", o_wb_ack, 0);
    chk("req_ready_rd_end", o_req_ready, 1);
  endtask

  initial begin
    int          idx;
    logic [31:0] a;
    sel = 1'b0; rst_n0 = 1'b0; rst_n1 = 1'b0;
    t_req_valid = 1'b0; t_req_write = 1'b0; t_req_addr = '0;
    t_wr_valid = 1'b0; t_wr_data = '0; t_rd_ready = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < NL; l++) m_vld[s][l] = 1'b0;
    #12;
    chk_reset_outputs("reset_lat4");
    sel = 1'b1; #1;
    chk_reset_outputs("reset_lat0");
    sel = 1'b0;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    step();

    // Directed writeback then refill of line 0x40, then a backpressured refill.
    for (int w = 0; w < WORDS; w++) wdat[w] = 32'h11 + 32'(w);
    do_write(32'h40, 0, 1'b0, -1);
    do_read(32'h40, -1, 0, 1'b0, 1'b0);
    do_read(32'h40, 2, 3, 1'b0, 1'b0);

    // Writeback with a bubble every other cycle.
    for (int w = 0; w < WORDS; w++) wdat[w] = 32'hB0 + 32'(w);
    do_write(32'h80, 1, 1'b0, -1);
    do_read(32'h80, -1, 0, 1'b0, 1'b0);

    // Reset after three beats: first three words new, rest keep 0x14..0x18.
    for (int w = 0; w < WORDS; w++) wdat[w] = 32'hA0 + 32'(w);
    do_write(32'h40, 0, 1'b0, 3);
    do_read(32'h40, -1, 0, 1'b0, 1'b0);

    // Upper address bits alias onto the same line.
    for (int w = 0; w < WORDS; w++) wdat[w] = 32'hC0 + 32'(w);
    do_write(32'h0000_0840, 0, 1'b0, -1);
    do_read(32'h0000_0047, -1, 0, 1'b0, 1'b0);

    // Randomized traffic over a small set of lines with random offsets/upper bits.
    for (int k = 0; k < 24; k++) begin
      idx = $urandom_range(0, 3);
      a   = ($urandom & 32'hFFFF_F81F) | (32'(idx) << 5);
      if ($urandom_range(0, 1) == 1 || !m_vld[0][idx]) begin
        for (int w = 0; w < WORDS; w++) wdat[w] = $urandom;
        do_write(a, $urandom_range(0, 2), 1'b0, -1);
      end else begin
        do_read(a, $urandom_range(0, WORDS - 1), $urandom_range(0, 3), 1'b1, 1'b0);
      end
    end

    // Zero-latency instance with req_valid held through the bursts.
    sel = 1'b1;
    #1;
    for (int w = 0; w < WORDS; w++) wdat[w] = 32'h51 + 32'(w);
    do_write(32'h1000, 0, 1'b1, -1);
    do_read(32'h1000, -1, 0, 1'b0, 1'b1);
    t_req_valid = 1'b0;
    do_read(32'h1000, 5, 2, 1'b1, 1'b0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
